// File: rtl/dev_arbiter_pkg.sv
// Shared definitions for dev_arbiter: FSM encoding, device address map and
// the address decoder used on the latched request address.
package dev_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam logic [31:0] DEV0_BASE = 32'h0000_7F00;
  localparam logic [31:0] DEV1_BASE = 32'h0000_7F40;
  localparam logic [31:0] DEADBEEF  = 32'hDEAD_BEEF;

  // addr is the word address [31:2]; each device owns one 64-byte window.
  function automatic logic [1:0] decode_sel(input logic [29:0] addr);
    logic [1:0] sel;
    sel = 2'b00;
    if (addr[29:4] == DEV0_BASE[31:6]) begin
      sel = 2'b01;
    end else if (addr[29:4] == DEV1_BASE[31:6]) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

endpackage

// File: rtl/dev_arbiter_rr_pick.sv
// Two-requester round-robin choice: on contention the requester that was
// not served last wins; otherwise the single active requester wins.
module rr_pick (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic valid_o,
  output logic gnt_o
);

  assign valid_o = req0_i | req1_i;
  assign gnt_o   = (req0_i & req1_i) ? ~last_i : req1_i;

endmodule

// File: rtl/dev_arbiter.sv
// Arbitrates a CPU and a DMA requester onto two memory-mapped devices.
// Optional watchdog on device acknowledge is enabled with ARB_TIMEOUT_EN.
module dev_arbiter
  import dev_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        dev_stb,
  output logic [1:0]  dev_sel,
  output logic        dev_we,
  output logic [3:0]  dev_addr,
  output logic [31:0] dev_wdata,
  input  logic        dev_ack,
  input  logic [31:0] dev_rdata0,
  input  logic [31:0] dev_rdata1,
  output logic        err
);

  arb_state_e  state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        err_q, err_d;

  logic        pick_valid;
  logic        pick_gnt;
  logic        cap_en;
  logic [31:0] cap_data;
  logic [1:0]  sel_w;
  logic        mapped_w;
  logic        busy_w;

  rr_pick u_rr_pick (
    .req0_i  (m0_req),
    .req1_i  (m1_req),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .gnt_o   (pick_gnt)
  );

  assign sel_w    = decode_sel(addr_q);
  assign mapped_w = |sel_w;
  assign busy_w   = (state_q == BUSY);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = 1'b0;
    cap_en   = 1'b0;
    cap_data = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = '0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          we_d    = pick_gnt ? m1_we    : m0_we;
          addr_d  = pick_gnt ? m1_addr  : m0_addr;
          wdata_d = pick_gnt ? m1_wdata : m0_wdata;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!mapped_w) begin
          cap_en  = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (dev_ack) begin
          cap_en   = 1'b1;
          cap_data = sel_w[1] ? dev_rdata1 : dev_rdata0;
          state_d  = DONE;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_LAST) begin
          cap_en   = 1'b1;
          cap_data = DEADBEEF;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdata0_d = (cap_en && !gnt_q) ? cap_data : rdata0_q;
    rdata1_d = (cap_en &&  gnt_q) ? cap_data : rdata1_q;
  end

  // last_q resets to 1 so that requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
    end
  end

  assign dev_stb   = busy_w & mapped_w;
  assign dev_sel   = busy_w ? sel_w : 2'b00;
  assign dev_we    = busy_w & we_q;
  assign dev_addr  = addr_q[3:0];
  assign dev_wdata = wdata_q;
  assign m0_done   = (state_q == DONE) & ~gnt_q;
  assign m1_done   = (state_q == DONE) &  gnt_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign err       = err_q;

endmodule

// File: doc/dev_arbiter.md
DEV_ARBITER -- requirements
Module: dev_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, watchdog limit in cycles, legal range 2..255.
REQ-002 SHALL have ports clk input 1 (system clock, rising edge) and rst input 1 (asynchronous, active-low reset).
REQ-003 SHALL have ports m0_req input 1, m0_we input 1, m0_addr input 30 ([31:2]), m0_wdata input 32, m0_done output 1 and m0_rdata output 32 for requester 0 (CPU).
REQ-004 SHALL have ports m1_req, m1_we, m1_addr, m1_wdata, m1_done and m1_rdata, with the same widths and directions, for requester 1 (DMA).
REQ-005 SHALL have device-side outputs dev_stb 1, dev_sel 2 (one-hot), dev_we 1, dev_addr 4 ([5:2] word offset) and dev_wdata 32.
REQ-006 SHALL have device-side inputs dev_ack 1 and dev_rdata0 and dev_rdata1, each 32.
REQ-007 SHALL have output err 1, a one-cycle pulse on a decode error or timeout.

Function
REQ-008 SHALL be an FSM with states IDLE, BUSY and DONE.
REQ-009 In IDLE with any req high: SHALL grant using round-robin; when both request, the requester not served last wins; after reset requester 0 wins.
REQ-010 On grant: SHALL latch we, addr and wdata of the winner, then move to BUSY on the next edge.
REQ-011 Decode on latched addr[31:6]:
- 0x7F00>>6 selects dev0.
- 0x7F40>>6 selects dev1.
- Any other address is unmapped.
REQ-012 BUSY with a mapped address:
- dev_stb=1, dev_sel, dev_we, dev_addr and dev_wdata held stable.
- On dev_ack: capture dev_rdata of the selected device, move to DONE.
REQ-013 BUSY with an unmapped address: dev_stb stays 0, captured rdata=0, err pulses, moves to DONE after one cycle.
REQ-014 DONE lasts exactly one cycle:
- The granted mX_done=1 and mX_rdata=captured data; then return to IDLE.
- The round-robin pointer updates here.
REQ-015 Minimum latency SHALL be: req sampled at edge N, dev_stb high after N, ack at N+1, done high in cycle N+2 (three cycles per transaction).
REQ-016 A requester holding req through DONE SHALL be treated as a new request in IDLE; requesters drop req in the cycle done is seen.
REQ-017 mX_rdata SHALL hold its last captured value until the next completion for that requester.
REQ-018 dev_ack outside BUSY SHALL be ignored.
REQ-019 A req change during BUSY SHALL have no effect on the transaction in flight.

Reset
REQ-020 On rst low, asynchronously:
- State=IDLE and the round-robin pointer selects requester 0.
- dev_stb=0, dev_sel=0, dev_we=0, dev_addr=0, dev_wdata=0.
- m0_done=0, m1_done=0, m0_rdata=0, m1_rdata=0, err=0.
- The timeout counter is cleared.
REQ-021 Reset mid-BUSY SHALL abandon the transaction with no done pulse.

Configuration
REQ-022 With ARB_TIMEOUT_EN defined:
- A counter runs while in BUSY.
- If TIMEOUT cycles pass without dev_ack: dev_stb drops, rdata=32'hDEADBEEF, err pulses, FSM moves to DONE.
REQ-023 With ARB_TIMEOUT_EN undefined: no counter, and BUSY waits indefinitely for dev_ack.

Structure
REQ-024 A shared package SHALL hold:
- State encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- Base constants DEV0_BASE=32'h7F00 and DEV1_BASE=32'h7F40.
- DEADBEEF.
REQ-025 A sub-module rr_pick SHALL compute the two-requester round-robin choice combinationally from the reqs and the last-grant bit.

Verification
REQ-026 m0 read at 0x7F04, dev_ack one cycle later with dev_rdata0=0x12345678 -> dev_sel=01 and dev_addr=1; m0_done in cycle N+2 with m0_rdata=0x12345678.
REQ-027 m0 and m1 both request continuously, each dropping and re-raising around done -> grants alternate 0,1,0,1; no requester starves.
REQ-028 m1 write at 0x7F48 with wdata 0xA5A5A5A5 -> dev_sel=10, dev_we=1, dev_addr=2, dev_wdata=0xA5A5A5A5 until ack; m1_done follows.
REQ-029 m0 read at 0x1000 -> dev_stb never rises; err pulse; m0_rdata=0 with m0_done.
REQ-030 ARB_TIMEOUT_EN defined, TIMEOUT=4, no ack -> dev_stb high for 4 cycles; then err, m0_done, m0_rdata=0xDEADBEEF.
REQ-031 rst low while in BUSY -> all outputs 0 immediately; no done pulse; the next grant goes to m0 when both request.
